// File: rtl/load_byte_assembler.sv
// Byte-serial load assembler: reads 1/2/4 bytes over an 8-bit port, little-endian, then extends.
// Define LOAD_BYTE_ASSEMBLER_ALIGN_CHECK_EN to reject misaligned half/word requests.
module load_byte_assembler #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_data,
    input  logic                  mem_ack,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [1:0]              size_q, size_d;
    logic                    signed_q, signed_d;
    logic [2:0]              count_q, count_d;
    logic [DATA_WIDTH-1:0]   asm_q, asm_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    ready_q, ready_d;
    logic                    reject;
    logic [2:0]              nbytes;
    logic                    last_byte;

    // Same replication rules as the downstream sign-extension stage.
    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] v,
                                                     input logic [1:0] sz, input logic sgn);
        logic [DATA_WIDTH-1:0] r;
        case (sz)
            2'b00:   r = {{(DATA_WIDTH-8){sgn & v[7]}}, v[7:0]};
            2'b01:   r = {{(DATA_WIDTH-16){sgn & v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

`ifdef LOAD_BYTE_ASSEMBLER_ALIGN_CHECK_EN
    assign reject = (req_size == 2'b11)
                 || ((req_size == 2'b01) && req_addr[0])
                 || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign reject = (req_size == 2'b11);
`endif

    always_comb begin
        nbytes = 3'd1;
        case (size_q)
            2'b01:   nbytes = 3'd2;
            2'b10:   nbytes = 3'd4;
            default: nbytes = 3'd1;
        endcase
    end

    assign last_byte = ((count_q + 3'd1) == nbytes);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        size_d     = size_q;
        signed_d   = signed_q;
        count_d    = count_q;
        asm_d      = asm_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid && ready_q) begin
                    base_d     = req_addr;
                    size_d     = req_size;
                    signed_d   = req_signed;
                    count_d    = 3'd0;
                    asm_d      = '0;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    if (reject) begin
                        rsp_err_d = 1'b1;
                        state_d   = StResp;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (mem_ack) begin
                    asm_d[{count_q[1:0], 3'b000} +: 8] = mem_data;
                    count_d = count_q + 3'd1;
                    if (last_byte) begin
                        rsp_data_d = extend(asm_d, size_q, signed_q);
                        state_d    = StResp;
                    end
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered so req_ready stays low through reset without an input-to-output path.
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            base_q     <= '0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            count_q    <= 3'd0;
            asm_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            count_q    <= count_d;
            asm_q      <= asm_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            ready_q    <= ready_d;
        end
    end

    assign req_ready = ready_q;
    assign mem_rd    = (state_q == StRead);
    assign mem_addr  = base_q + ADDR_WIDTH'(count_q);
    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_byte_assembler.sv
// Self-checking bench for load_byte_assembler: directed vector table, reset corner cases,
// and randomized loads against a byte-array memory model.
module tb_load_byte_assembler;

`ifdef LOAD_BYTE_ASSEMBLER_ALIGN_CHECK_EN
    localparam bit Align = 1'b1;
`else
    localparam bit Align = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ack;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic [7:0]  mem [0:65535];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_byte_assembler #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_signed(req_signed),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ack   (mem_ack),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  size;
        logic        sgn;
        int          waits;
        int          hold;
        logic [31:0] bytes;   // byte i at addr+i taken from bits [8i+7:8i]
        logic [31:0] data;
        logic        err;
        int          cyc;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic [15:0] addr, input logic [1:0] size, input logic sgn,
                                input int waits, input int hold, input logic [31:0] bytes,
                                input logic [31:0] data, input logic err, input int cyc);
        vec_t v;
        v.addr = addr; v.size = size; v.sgn = sgn; v.waits = waits; v.hold = hold;
        v.bytes = bytes; v.data = data; v.err = err; v.cyc = cyc;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: gather n bytes little-endian with 16-bit wrap, then two's-complement extend.
    function automatic logic [31:0] ref_data(input logic [15:0] addr, input int n, input logic sgn);
        longint v;
        longint full;
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(mem[16'(addr + i)]) << (8 * i);
        full = longint'(1) << (8 * n);
        if (sgn && (v >= full / 2)) v = v - full;
        return v[31:0];
    endfunction

    task automatic run_load(input string name, input logic [15:0] addr, input logic [1:0] size,
                            input logic sgn, input int waits, input int hold,
                            input logic [31:0] exp_data, input logic exp_err, input int exp_cyc);
        int budget;
        int cyc;
        int wcnt;
        int nrd;
        int nacks;
        int nb;
        logic [15:0] exp_addr;

        budget = 0;
        while (!req_ready && budget < 20) begin
            tick();
            budget++;
        end
        check({name, " req_ready before accept"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        tick();
        req_valid  = 1'b0;
        req_addr   = 16'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);

        cyc = 1; wcnt = 0; nrd = 0; nacks = 0;
        nb = exp_err ? 0 : (1 << size);
        while (!rsp_valid && cyc < 200) begin
            if (mem_rd) begin
                nrd++;
                exp_addr = addr + 16'(nacks);
                check({name, " mem_addr"}, 32'(mem_addr), 32'(exp_addr));
                if (wcnt < waits) begin
                    mem_ack = 1'b0;
                    wcnt++;
                end else begin
                    mem_ack  = 1'b1;
                    mem_data = mem[mem_addr];
                    wcnt = 0;
                    nacks++;
                end
            end else begin
                mem_ack = 1'b0;
            end
            tick();
            cyc++;
        end
        mem_ack = 1'b0;

        check({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({name, " rsp cycle"}, 32'(cyc), 32'(exp_cyc));
        check({name, " rsp_data"}, rsp_data, exp_data);
        check({name, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check({name, " bytes read"}, 32'(nacks), 32'(nb));
        if (exp_err) check({name, " mem_rd cycles"}, 32'(nrd), 32'd0);
        check({name, " mem_rd in RESP"}, 32'(mem_rd), 32'd0);
        check({name, " req_ready in RESP"}, 32'(req_ready), 32'd0);

        for (int h = 0; h < hold; h++) begin
            tick();
            check({name, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
            check({name, " hold rsp_data"}, rsp_data, exp_data);
            check({name, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({name, " rsp_valid after handshake"}, 32'(rsp_valid), 32'd0);
        check({name, " req_ready after handshake"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        logic [1:0]  sz;
        logic        sg;
        int          n;
        logic        er;
        int          w;

        reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0; req_signed = 1'b0;
        mem_data = '0; mem_ack = 1'b0; rsp_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset mem_rd", 32'(mem_rd), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_data", rsp_data, 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;
        tick();
        check("req_ready after release", 32'(req_ready), 32'd1);

        // Directed vectors
        add(16'h0004, 2'b00, 1'b1, 0, 0, 32'h0000_0080, 32'hFFFF_FF80, 1'b0, 2);
        add(16'h0004, 2'b00, 1'b0, 0, 0, 32'h0000_0080, 32'h0000_0080, 1'b0, 2);
        add(16'h0010, 2'b01, 1'b1, 0, 0, 32'h0000_8234, 32'hFFFF_8234, 1'b0, 3);
        add(16'h0020, 2'b10, 1'b1, 2, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 13);
        add(16'h0040, 2'b10, 1'b1, 0, 3, 32'hF403_0201, 32'hF403_0201, 1'b0, 5);
        add(16'h0050, 2'b01, 1'b0, 0, 0, 32'h0000_80FF, 32'h0000_80FF, 1'b0, 3);
        add(16'h0052, 2'b01, 1'b1, 1, 0, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0, 5);
        add(16'h0060, 2'b00, 1'b1, 0, 1, 32'h0000_007F, 32'h0000_007F, 1'b0, 2);
        add(16'h0061, 2'b00, 1'b1, 3, 0, 32'h0000_00FF, 32'hFFFF_FFFF, 1'b0, 5);
        add(16'h0100, 2'b11, 1'b1, 0, 2, 32'h1122_3344, 32'h0000_0000, 1'b1, 1);
`ifdef LOAD_BYTE_ASSEMBLER_ALIGN_CHECK_EN
        add(16'h0011, 2'b01, 1'b1, 0, 0, 32'h0000_2211, 32'h0000_0000, 1'b1, 1);
        add(16'hFFFF, 2'b01, 1'b0, 0, 0, 32'h0000_BBAA, 32'h0000_0000, 1'b1, 1);
        add(16'h0022, 2'b10, 1'b0, 0, 0, 32'hA1B2_C3D4, 32'h0000_0000, 1'b1, 1);
`else
        add(16'h0011, 2'b01, 1'b1, 0, 0, 32'h0000_2211, 32'h0000_2211, 1'b0, 3);
        add(16'hFFFF, 2'b01, 1'b0, 0, 0, 32'h0000_BBAA, 32'h0000_BBAA, 1'b0, 3);
        add(16'hFFFE, 2'b10, 1'b1, 0, 0, 32'h8877_6655, 32'h8877_6655, 1'b0, 5);
`endif

        foreach (vq[i]) begin
            for (int b = 0; b < 4; b++) mem[16'(vq[i].addr + b)] = vq[i].bytes[8*b +: 8];
            run_load($sformatf("vec%0d", i), vq[i].addr, vq[i].size, vq[i].sgn, vq[i].waits,
                     vq[i].hold, vq[i].data, vq[i].err, vq[i].cyc);
        end

        // Reset in the middle of a word load, then a stale ack
        mem[16'h0080] = 8'hC3;
        req_valid = 1'b1; req_addr = 16'h0080; req_size = 2'b10; req_signed = 1'b1;
        tick();
        req_valid = 1'b0;
        mem_ack = 1'b1; mem_data = 8'h11;
        tick();
        mem_data = 8'h22;
        tick();
        check("midreset mem_rd before reset", 32'(mem_rd), 32'd1);
        check("midreset mem_addr before reset", 32'(mem_addr), 32'h0082);
        reset = 1'b0;
        tick();
        check("midreset mem_rd", 32'(mem_rd), 32'd0);
        check("midreset rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset req_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("stale ack rsp_valid", 32'(rsp_valid), 32'd0);
            check("stale ack mem_rd", 32'(mem_rd), 32'd0);
            check("stale ack req_ready", 32'(req_ready), 32'd1);
        end
        mem_ack = 1'b0;
        run_load("post-reset byte", 16'h0080, 2'b00, 1'b1, 0, 0, 32'hFFFF_FFC3, 1'b0, 2);

        // Randomized loads against the reference model
        for (int r = 0; r < 40; r++) begin
            a  = 16'($urandom);
            if (r % 5 == 0) a = 16'hFFFF - 16'($urandom_range(0, 2));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom);
            w  = $urandom_range(0, 3);
            n  = 1 << sz;
            for (int b = 0; b < 4; b++) mem[16'(a + b)] = 8'($urandom);
            er = (sz == 2'b11) || (Align && ((int'(a) % n) != 0));
            run_load($sformatf("rnd%0d", r), a, sz, sg, w, $urandom_range(0, 2),
                     er ? 32'd0 : ref_data(a, n, sg), er, er ? 1 : 1 + n * (w + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_byte_assembler.md
# load_byte_assembler

Load-path stage that sits directly upstream of the sign-extension stage in the CPU datapath. It accepts a byte, halfword or word load request and performs the required byte reads over an 8-bit memory port, assembling them little-endian. It then zero- or sign-extends the result to 32 bits and returns it with a valid/ready handshake. The extension uses the same sign-extension rules as the downstream stage.

## Interface
- ADDR_WIDTH, 16, byte address width
- DATA_WIDTH, 32, response width (fixed at 32; other values unsupported)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- req_valid  input  1  load request present
- req_ready  output  1  block can accept a request
- req_addr  input  ADDR_WIDTH  byte address of the load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  input  1  1 = sign-extend, 0 = zero-extend
- mem_rd  output  1  memory read strobe
- mem_addr  output  ADDR_WIDTH  memory byte address
- mem_data  input  8  read data, valid when mem_ack=1
- mem_ack  input  1  read completed this cycle
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  32  extended load result
- rsp_err  output  1  request rejected; no memory access was made

## Operation
- The FSM has three states: IDLE, READ and RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid&&req_ready, the block latches addr, size and signed, clears the byte counter and the assembly register, and moves to READ.
  - A request with size 11 does not go to READ. It goes directly to RESP with rsp_err=1 and rsp_data=0.
  - A misaligned request (see Configuration) is handled the same way as size 11.
- **READ**
  - mem_rd=1 and mem_addr = base + count, truncated to ADDR_WIDTH, so addresses wrap from all-ones to 0.
  - Outputs hold stable until mem_ack.
  - On mem_ack, mem_data is written into byte lane `count` and count increments.
  - After the last byte (1, 2 or 4 bytes), the FSM moves to RESP and mem_rd deasserts on that same edge.
- **RESP**
  - rsp_valid=1.
  - rsp_data holds the extended value: bit 7, 15 or 31 of the assembled value is replicated upward when signed. Unsigned loads are zero-extended.
  - rsp_data and rsp_err stay stable until rsp_valid&&rsp_ready, after which the FSM returns to IDLE.
- **Ignored input:** mem_ack outside READ has no effect, including a late ack after a reset.
- **Reset values**
  - State = IDLE.
  - mem_rd=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, count=0.
  - req_ready=0 while reset is low, and 1 from the first cycle after reset is released.
- **Reset mid-operation:** the request is abandoned with no response, and mem_rd is 0 after the reset edge.

## Timing
- req_ready equals (state==IDLE) gated by reset. There are no back-to-back accepts; at least one cycle separates a response handshake from the next accept.
- Cycle 0 is the accept edge.
  - mem_rd asserts in cycle 1.
  - With zero-wait acks, byte k is read in cycle 1+k.
  - rsp_valid asserts in cycle 1+N, where N is the byte count.
  - Minimum latency is therefore 2 cycles for a byte, 3 for a half and 5 for a word.
- Each wait cycle (mem_rd=1, mem_ack=0) adds one cycle.
- An error response asserts rsp_valid in cycle 1, with no mem_rd at any point.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to an output.

## Configuration
- The macro `LOAD_BYTE_ASSEMBLER_ALIGN_CHECK_EN` selects how misaligned requests are handled.
- **Defined:**
  - A half with addr[0]=1 is rejected.
  - A word with addr[1:0]≠00 is rejected.
  - A rejected request gets rsp_err=1, rsp_data=0 and performs no memory reads.
- **Undefined:**
  - Misaligned requests are processed normally, byte by byte from addr upward, with address wrap-around.
  - rsp_err is set only for size 11.

## Test plan
- **Byte, signed then unsigned:** byte at 0x0004 with mem_data=0x80 and zero-wait ack.
  - Signed gives rsp_data=0xFFFFFF80 at cycle 2.
  - Unsigned gives 0x00000080.
- **Signed half:** signed half at 0x0010 with bytes 0x34, 0x82 → rsp_data=0xFFFF8234, mem_addr sequence 0x0010, 0x0011.
- **Word with wait states:** word at 0x0020 with bytes 0x78, 0x56, 0x34, 0x12, each acked after 2 wait cycles → rsp_data=0x12345678, rsp_valid at cycle 13, rsp_err=0.
- **Misaligned half:**
  - Half at 0x0011 with the macro defined → rsp_err=1, rsp_data=0, mem_rd never asserted.
  - Without the macro and at 0xFFFF, bytes are read from 0xFFFF then 0x0000.
- **Backpressure:** hold rsp_ready=0 for 3 cycles in RESP → rsp_data stable, req_ready=0 throughout; return to IDLE one cycle after rsp_ready=1.
- **Reset mid-operation:** assert reset after 2 bytes of a word → next cycle mem_rd=0, rsp_valid=0. A stale mem_ack is ignored, and a following byte load returns the correct value.
